arbitro_vc: RTL and testbench
=============================

Name: arbitro_vc

Overview:
Weighted round-robin scheduler that shares one destination FIFO between four virtual-channel source FIFOs (VC0..VC3). It sits downstream of the qos flow controller and obeys its per-VC pausa/continuar commands and its error_full flag. It moves one word per cycle from the granted source FIFO into the destination FIFO. Source FIFOs are show-ahead: data is valid whenever empty is 0.

Parameters:
DATA_WIDTH, 6, width of one data word
PESO0, 4, VC0 weight: max consecutive pops per turn (1..15)
PESO1, 3, VC1 weight (1..15)
PESO2, 2, VC2 weight (1..15)
PESO3, 1, VC3 weight (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
enb  input  1  global enable; 0 freezes all state and forces pop/push to 0
iniciar  input  1  one-cycle pulse; moves INACTIVO to ACTIVO
error_full  input  1  from qos; forces ERROR
pausa  input  4  per-VC pause pulse from qos
continuar  input  4  per-VC resume pulse from qos
empty  input  4  source FIFO empty flags
almost_full_dest  input  1  destination FIFO almost-full
datos_in  input  4*DATA_WIDTH  source heads; VCi at bits [i*DATA_WIDTH +: DATA_WIDTH]
pop  output  4  one-hot source read strobe (combinational)
push  output  1  destination write strobe, equal to |pop
datos_out  output  DATA_WIDTH  head of the granted VC (combinational mux); 0 when push=0
vc_sel  output  2  index of the current turn owner (registered)
idle  output  1  1 when ACTIVO and all empty=1
estado  output  2  0=INACTIVO, 1=ACTIVO, 2=ERROR

Behaviour:
- Reset (rst=1 at clk edge) sets: estado=INACTIVO, vc_sel=0, credit=PESO0, pausado[3:0]=0. Reset dominates enb. With estado=INACTIVO, pop=0, push=0, idle=0 and datos_out=0.
- INACTIVO -> ACTIVO on iniciar=1.
- ACTIVO -> ERROR on error_full=1. error_full has priority over any grant in that cycle: pop=0.
- ERROR -> INACTIVO only through rst.
- Pause flags:
  - pausa[i] sets pausado[i]; continuar[i] clears it.
  - If both are high in the same cycle, pausa wins.
  - Flags update in all states while enb=1.
- Eligibility: elig[i] = !empty[i] & !pausado[i].
- Grant rule, evaluated combinationally from registered state, only when enb=1, ACTIVO and almost_full_dest=0:
  - If elig[vc_sel] and credit>0, grant vc_sel.
  - Otherwise grant the first eligible VC searching vc_sel+1, vc_sel+2, vc_sel+3 (mod 4).
  - Otherwise no grant.
- Outputs on a grant g: pop[g]=1, push=1, datos_out=datos_in slice g. Zero latency; the data transfer happens in the grant cycle.
- Clock update on a grant g:
  - If g==vc_sel, credit <= credit-1.
  - Otherwise vc_sel <= g and credit <= PESOg-1.
  - When credit would reach 0, vc_sel still equals g. The next cycle forces a search that skips vc_sel. If no other VC is eligible, vc_sel is re-granted and credit reloads to PESOg-1.
- No grant: vc_sel and credit hold.
- almost_full_dest=1 stalls all grants. Credits are preserved.
- A pausa[i] pulse takes effect the next cycle. A pop already granted in the current cycle completes.
- Credit counter is 4 bits wide. Weights outside 1..15 are illegal; use an initial-block check under simulation.

Optional Feature:
ARBITRO_PRIO_VC0_EN
- Defined: VC0 is strict priority. When elig[0]=1 and a grant is allowed, VC0 wins. Its grant does not change vc_sel or credit; round-robin among VC1..VC3 resumes unchanged afterwards. PESO0 is ignored.
- Undefined: all four VCs take part in weighted round-robin as above.

Decomposition:
- Shared package: estado encodings (INACTIVO=0, ACTIVO=1, ERROR=2), NUM_VC=4, and the weight-range constants.
- One natural sub-module: rr_busca, a combinational rotate-priority finder. Inputs: 4-bit request vector and 2-bit start pointer. Outputs: one-hot grant and valid.

Test Plan:
- Basic WRR: rst then iniciar; all four VCs non-empty, no pausa, almost_full_dest=0 -> pop sequence VC0 x4, VC1 x3, VC2 x2, VC3 x1, then repeats; push=1 every cycle.
- Empty skip: empty=4'b1010 steady -> pops alternate VC0 x4, VC2 x2; vc_sel never equals 1 or 3.
- Pause/resume: pausa[0] pulse during a VC0 turn -> from the next cycle no pop[0]; continuar[0] later restores pop[0] on its next turn. pausa[2] and continuar[2] in the same cycle -> VC2 stays paused.
- Backpressure: almost_full_dest=1 for 5 cycles mid VC1 turn with 1 credit left -> pop=0 and push=0 for 5 cycles; afterwards exactly one more VC1 pop, then VC2.
- Error: error_full=1 -> pop=0 in that same cycle; estado=2 next cycle; iniciar ignored; rst returns estado to 0.
- ARBITRO_PRIO_VC0_EN build: VC0 made non-empty during a VC2 turn -> VC0 popped every cycle until empty; then VC2 resumes with its remaining credit.

Source files
------------

// File: rtl/arbitro_vc_pkg.sv
// Shared types and constants for the arbitro_vc weighted round-robin scheduler.
package arbitro_vc_pkg;

   typedef enum logic [1:0] {
      StInactivo = 2'd0,
      StActivo   = 2'd1,
      StError    = 2'd2
   } estado_e;

   localparam int unsigned NUM_VC   = 4;
   localparam int unsigned PESO_MIN = 1;
   localparam int unsigned PESO_MAX = 15;

   function automatic logic peso_valido(int unsigned peso);
      return (peso >= PESO_MIN) && (peso <= PESO_MAX);
   endfunction

endpackage

// File: rtl/arbitro_vc_rr_busca.sv
// Combinational rotate-priority finder: first set request at or after start_i (mod NUM_VC).
module arbitro_vc_rr_busca
   import arbitro_vc_pkg::*;
(
   input  logic [NUM_VC-1:0] req_i,
   input  logic [1:0]        start_i,
   output logic [NUM_VC-1:0] gnt_o,
   output logic              valid_o
);

   logic [1:0] idx;

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      idx     = start_i;
      for (int k = 0; k < NUM_VC; k++) begin
         idx = start_i + 2'(k);
         if (!valid_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_vc.sv
// Weighted round-robin scheduler moving one word per cycle from four VC FIFOs to one destination.
// Optional build macro ARBITRO_PRIO_VC0_EN makes VC0 strict priority outside the round-robin.
module arbitro_vc
   import arbitro_vc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 6,
   parameter int unsigned PESO0      = 4,
   parameter int unsigned PESO1      = 3,
   parameter int unsigned PESO2      = 2,
   parameter int unsigned PESO3      = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enb,
   input  logic                         iniciar,
   input  logic                         error_full,
   input  logic [NUM_VC-1:0]            pausa,
   input  logic [NUM_VC-1:0]            continuar,
   input  logic [NUM_VC-1:0]            empty,
   input  logic                         almost_full_dest,
   input  logic [NUM_VC*DATA_WIDTH-1:0] datos_in,
   output logic [NUM_VC-1:0]            pop,
   output logic                         push,
   output logic [DATA_WIDTH-1:0]        datos_out,
   output logic [1:0]                   vc_sel,
   output logic                         idle,
   output logic [1:0]                   estado
);

   function automatic logic [3:0] peso_de(logic [1:0] vc);
      case (vc)
         2'd0:    return 4'(PESO0);
         2'd1:    return 4'(PESO1);
         2'd2:    return 4'(PESO2);
         default: return 4'(PESO3);
      endcase
   endfunction

`ifndef SYNTHESIS
   initial begin
      if (!peso_valido(PESO0) || !peso_valido(PESO1) || !peso_valido(PESO2) ||
          !peso_valido(PESO3)) begin
         $fatal(1, "arbitro_vc: every PESOi must lie in 1..15");
      end
   end
`endif

   estado_e     estado_q, estado_d;
   logic [1:0]  vc_sel_q, vc_sel_d;
   logic [3:0]  credit_q, credit_d;
   logic [3:0]  pausado_q, pausado_d;

   logic [NUM_VC-1:0] elig, rr_req, busca_gnt, gnt;
   logic              busca_valid, permite, prio_hit, mantiene, rr_ok, avanza;
   logic [1:0]        rr_idx;

   assign elig    = ~empty & ~pausado_q;
   // error_full outranks any grant in the cycle it is raised
   assign permite = enb && (estado_q == StActivo) && !almost_full_dest && !error_full;

`ifdef ARBITRO_PRIO_VC0_EN
   assign rr_req   = elig & 4'b1110;
   assign prio_hit = elig[0];
`else
   assign rr_req   = elig;
   assign prio_hit = 1'b0;
`endif

   // Search begins after the owner; it wraps back to the owner only when nobody else qualifies
   arbitro_vc_rr_busca u_busca (
      .req_i   (rr_req),
      .start_i (vc_sel_q + 2'd1),
      .gnt_o   (busca_gnt),
      .valid_o (busca_valid)
   );

   assign mantiene = rr_req[vc_sel_q] && (credit_q != 4'd0);

   always_comb begin
      rr_idx = vc_sel_q;
      rr_ok  = mantiene;
      if (!mantiene && busca_valid) begin
         rr_ok = 1'b1;
         for (int k = 0; k < NUM_VC; k++) begin
            if (busca_gnt[k]) rr_idx = 2'(k);
         end
      end

      gnt = '0;
      if (permite) begin
         if (prio_hit)   gnt = 4'b0001;
         else if (rr_ok) gnt[rr_idx] = 1'b1;
      end

      datos_out = '0;
      for (int k = 0; k < NUM_VC; k++) begin
         if (gnt[k]) datos_out = datos_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign pop    = gnt;
   assign push   = |gnt;
   assign avanza = permite && !prio_hit && rr_ok;
   assign vc_sel = vc_sel_q;
   assign estado = estado_q;
   assign idle   = (estado_q == StActivo) && (&empty);

   always_comb begin
      estado_d  = estado_q;
      vc_sel_d  = vc_sel_q;
      credit_d  = credit_q;
      pausado_d = (pausado_q & ~continuar) | pausa;

      unique case (estado_q)
         StInactivo: if (iniciar) estado_d = StActivo;
         StActivo:   if (error_full) estado_d = StError;
         default:    estado_d = estado_q;
      endcase

      if (avanza) begin
         if ((rr_idx == vc_sel_q) && (credit_q != 4'd0)) begin
            credit_d = credit_q - 4'd1;
         end else begin
            vc_sel_d = rr_idx;
            credit_d = peso_de(rr_idx) - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q  <= StInactivo;
         vc_sel_q  <= 2'd0;
         credit_q  <= 4'(PESO0);
         pausado_q <= '0;
      end else if (enb) begin
         estado_q  <= estado_d;
         vc_sel_q  <= vc_sel_d;
         credit_q  <= credit_d;
         pausado_q <= pausado_d;
      end
   end

endmodule

// File: tb/tb_arbitro_vc.sv
// Self-checking bench for arbitro_vc: directed scenarios plus randomized traffic against a model.
module tb_arbitro_vc;

   localparam int DW = 6;
   localparam int P0 = 4;
   localparam int P1 = 3;
   localparam int P2 = 2;
   localparam int P3 = 1;
   localparam int OW = 4 + 1 + DW + 2 + 1 + 2;

   logic          clk = 1'b0;
   logic          rst, enb, iniciar, error_full, afd;
   logic [3:0]    pausa, continuar, empty;
   logic [4*DW-1:0] datos_in;
   wire  [3:0]    pop;
   wire           push;
   wire  [DW-1:0] datos_out;
   wire  [1:0]    vc_sel, estado;
   wire           idle;

   always #5 clk = ~clk;

   arbitro_vc #(
      .DATA_WIDTH (DW),
      .PESO0      (P0),
      .PESO1      (P1),
      .PESO2      (P2),
      .PESO3      (P3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .enb              (enb),
      .iniciar          (iniciar),
      .error_full       (error_full),
      .pausa            (pausa),
      .continuar        (continuar),
      .empty            (empty),
      .almost_full_dest (afd),
      .datos_in         (datos_in),
      .pop              (pop),
      .push             (push),
      .datos_out        (datos_out),
      .vc_sel           (vc_sel),
      .idle             (idle),
      .estado           (estado)
   );

   wire  [OW-1:0] obs = {pop, push, datos_out, vc_sel, idle, estado};
   logic [OW-1:0] exp_obs;
   int checks = 0;
   int errors = 0;

   // Reference model: state 0/1/2, turn owner, remaining pops in the turn, pause flags
   int       m_state, m_sel, m_cred, m_g;
   bit       m_prio;
   bit [3:0] m_paused;

   function automatic int peso(int i);
      case (i)
         0:       return P0;
         1:       return P1;
         2:       return P2;
         default: return P3;
      endcase
   endfunction

   task automatic model_eval();
      bit [3:0]      elig, pool;
      logic [3:0]    e_pop;
      logic [DW-1:0] e_dat;
      elig   = ~empty & ~m_paused;
      pool   = elig;
      m_g    = -1;
      m_prio = 1'b0;
`ifdef ARBITRO_PRIO_VC0_EN
      pool[0] = 1'b0;
`endif
      if (enb && m_state == 1 && !afd && !error_full) begin
`ifdef ARBITRO_PRIO_VC0_EN
         if (elig[0]) begin
            m_g    = 0;
            m_prio = 1'b1;
         end
`endif
         if (m_g < 0) begin
            if (pool[m_sel] && m_cred > 0) m_g = m_sel;
            else
               for (int off = 1; off <= 4; off++)
                  if (m_g < 0 && pool[(m_sel + off) % 4]) m_g = (m_sel + off) % 4;
         end
      end
      e_pop = '0;
      e_dat = '0;
      if (m_g >= 0) begin
         e_pop[m_g] = 1'b1;
         e_dat      = datos_in[m_g*DW +: DW];
      end
      exp_obs = {e_pop, |e_pop, e_dat, 2'(m_sel), (m_state == 1 && empty == 4'hF), 2'(m_state)};
   endtask

   task automatic model_update();
      if (rst) begin
         m_state  = 0;
         m_sel    = 0;
         m_cred   = P0;
         m_paused = '0;
      end else if (enb) begin
         if (m_state == 0 && iniciar) m_state = 1;
         else if (m_state == 1 && error_full) m_state = 2;
         if (m_g >= 0 && !m_prio) begin
            if (m_g == m_sel && m_cred > 0) m_cred--;
            else begin
               m_sel  = m_g;
               m_cred = peso(m_g) - 1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (pausa[i]) m_paused[i] = 1'b1;
            else if (continuar[i]) m_paused[i] = 1'b0;
         end
      end
   endtask

   task automatic step_begin();
      @(negedge clk);
      model_eval();
   endtask

   task automatic step_end();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      enb        = 1'b1;
      iniciar    = 1'b0;
      error_full = 1'b0;
      pausa      = '0;
      continuar  = '0;
      afd        = 1'b0;
   endtask

   task automatic restart();
      quiet();
      rst = 1'b1;
      step_begin();
      step_end();
      rst     = 1'b0;
      iniciar = 1'b1;
      step_begin();
      step_end();
      iniciar = 1'b0;
   endtask

   task automatic test_reset();
      quiet();
      enb       = 1'b0;
      rst       = 1'b1;
      pausa     = 4'($urandom);
      continuar = 4'($urandom);
      empty     = 4'($urandom);
      datos_in  = 24'($urandom);
      step_begin();
      step_end();
      quiet();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         empty    = 4'($urandom);
         datos_in = 24'($urandom);
         step_begin();
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc %0d got %h exp 0", c, obs);
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL reset_model cyc %0d got %h exp %h", c, obs, exp_obs);
         end
         step_end();
      end
   endtask

`ifndef ARBITRO_PRIO_VC0_EN
   task automatic test_basic_wrr();
      int seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
      restart();
      empty = '0;
      for (int k = 0; k < 20; k++) begin
         datos_in = 24'($urandom);
         step_begin();
         checks++;
         if (pop !== 4'(1 << seq[k % 10]) || push !== 1'b1) begin
            errors++;
            $display("FAIL wrr_seq k %0d got pop %b push %b exp pop %b push 1", k, pop, push,
                     4'(1 << seq[k % 10]));
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL wrr_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
   endtask

   task automatic test_backpressure();
      restart();
      empty = '0;
      for (int k = 0; k < 13; k++) begin
         afd      = (k >= 6 && k < 11);
         datos_in = 24'($urandom);
         step_begin();
         if (k >= 6 && k < 11) begin
            checks++;
            if (pop !== 4'b0 || push !== 1'b0) begin
               errors++;
               $display("FAIL bp_stall k %0d got pop %b push %b exp 0 0", k, pop, push);
            end
         end
         if (k >= 11) begin
            checks++;
            if (pop !== ((k == 11) ? 4'b0010 : 4'b0100)) begin
               errors++;
               $display("FAIL bp_resume k %0d got pop %b exp %b", k, pop,
                        (k == 11) ? 4'b0010 : 4'b0100);
            end
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL bp_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
      afd = 1'b0;
   endtask
`endif

   task automatic test_empty_skip();
      restart();
      empty = 4'b1010;
      for (int k = 0; k < 18; k++) begin
         datos_in = 24'($urandom);
         step_begin();
         checks++;
         if (!(pop == 4'b0001 || pop == 4'b0100) || vc_sel[0] !== 1'b0) begin
            errors++;
            $display("FAIL skip_vc k %0d got pop %b vc_sel %0d exp pop 0001/0100 even vc_sel",
                     k, pop, vc_sel);
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL skip_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
   endtask

   task automatic test_pause();
      int seen0;
      restart();
      empty = '0;
      seen0 = 0;
      for (int k = 0; k < 40; k++) begin
         pausa     = (k == 1) ? 4'b0001 : (k == 27) ? 4'b0100 : 4'b0000;
         continuar = (k == 14) ? 4'b0001 : (k == 27) ? 4'b0100 : 4'b0000;
         datos_in  = 24'($urandom);
         step_begin();
         if (k == 1 || (k >= 2 && k < 14)) begin
            checks++;
            if (pop[0] !== (k == 1)) begin
               errors++;
               $display("FAIL pause_vc0 k %0d got pop0 %b exp %b", k, pop[0], (k == 1));
            end
         end
         if (k > 14 && k < 27 && pop[0]) seen0++;
         if (k >= 28) begin
            checks++;
            if (pop[2] !== 1'b0) begin
               errors++;
               $display("FAIL pause_wins k %0d got pop2 %b exp 0", k, pop[2]);
            end
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL pause_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
      checks++;
      if (seen0 == 0) begin
         errors++;
         $display("FAIL resume_vc0 got %0d pops exp >0", seen0);
      end
   endtask

   task automatic test_error();
      restart();
      empty = '0;
      for (int k = 0; k < 7; k++) begin
         error_full = (k == 3);
         iniciar    = (k == 4);
         rst        = (k == 6);
         enb        = (k != 6);
         datos_in   = 24'($urandom);
         step_begin();
         checks++;
         if (k == 3 && (pop !== 4'b0 || push !== 1'b0)) begin
            errors++;
            $display("FAIL err_nopop got pop %b push %b exp 0 0", pop, push);
         end else if ((k == 4 || k == 5) && (estado !== 2'd2 || pop !== 4'b0)) begin
            errors++;
            $display("FAIL err_state k %0d got estado %0d pop %b exp 2 0", k, estado, pop);
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL err_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
      quiet();
      rst = 1'b0;
      step_begin();
      checks++;
      if (estado !== 2'd0) begin
         errors++;
         $display("FAIL err_reset got estado %0d exp 0", estado);
      end
      step_end();
   endtask

`ifdef ARBITRO_PRIO_VC0_EN
   task automatic test_prio();
      logic [3:0] exp_pops [9] = '{4'h2, 4'h2, 4'h2, 4'h4, 4'h1, 4'h1, 4'h1, 4'h4, 4'h8};
      restart();
      for (int k = 0; k < 9; k++) begin
         empty    = (k >= 4 && k < 7) ? 4'b0000 : 4'b0001;
         datos_in = 24'($urandom);
         step_begin();
         checks++;
         if (pop !== exp_pops[k]) begin
            errors++;
            $display("FAIL prio_seq k %0d got pop %b exp %b", k, pop, exp_pops[k]);
         end
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL prio_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
   endtask
`endif

   task automatic test_random();
      restart();
      for (int k = 0; k < 800; k++) begin
         rst        = ($urandom_range(0, 79) == 0);
         enb        = ($urandom_range(0, 9) != 0);
         iniciar    = ($urandom_range(0, 7) == 0);
         error_full = ($urandom_range(0, 149) == 0);
         afd        = ($urandom_range(0, 4) == 0);
         empty      = 4'($urandom) & 4'($urandom);
         datos_in   = 24'($urandom);
         for (int i = 0; i < 4; i++) begin
            pausa[i]     = ($urandom_range(0, 15) == 0);
            continuar[i] = ($urandom_range(0, 7) == 0);
         end
         step_begin();
         checks++;
         if (obs !== exp_obs) begin
            errors++;
            $display("FAIL rand_model k %0d got %h exp %h", k, obs, exp_obs);
         end
         step_end();
      end
      quiet();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      quiet();
      empty    = '1;
      datos_in = '0;
      m_state  = 0;
      m_sel    = 0;
      m_cred   = P0;
      m_paused = '0;
      m_g      = -1;
      m_prio   = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
`ifndef ARBITRO_PRIO_VC0_EN
      test_basic_wrr();
      test_backpressure();
`else
      test_prio();
`endif
      test_empty_skip();
      test_pause();
      test_error();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
